// File: rtl/tcdm_req_gen_pkg.sv
// Package for the TCDM traffic initiator.
// Holds the shared TCDM request/response payload types, the initiator FSM
// state encoding, the scoreboard entry layout and the LFSR step function.
package tcdm_req_gen_pkg;

  localparam int unsigned AddrWidth    = 32;
  localparam int unsigned DataWidth    = 32;
  localparam int unsigned BeWidth      = 4;
  localparam int unsigned AmoWidth     = 4;
  localparam int unsigned CoreIdWidth  = 8;
  localparam int unsigned TileIdWidth  = 8;
  localparam int unsigned IniAddrWidth = 8;
  localparam int unsigned MetaIdWidth  = 4;

  typedef logic [MetaIdWidth-1:0] meta_id_t;

  typedef struct packed {
    logic [IniAddrWidth-1:0] ini_addr;
    meta_id_t                meta_id;
    logic [TileIdWidth-1:0]  tile_id;
    logic [CoreIdWidth-1:0]  core_id;
    logic                    lrwait;
  } bank_metadata_t;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    logic [AmoWidth-1:0]  amo;
    logic [DataWidth-1:0] data;
    logic [BeWidth-1:0]   be;
    bank_metadata_t       meta;
  } tcdm_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    bank_metadata_t       meta;
  } tcdm_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } tcdm_req_gen_state_e;

  typedef struct packed {
    logic                 busy;
    logic                 is_write;
    logic [DataWidth-1:0] expected;
  } sb_entry_t;

  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
  localparam logic [31:0] LfsrTaps  = 32'h8020_0003;
  localparam logic [31:0] WdataMask = 32'h5A5A_5A5A;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] nxt;
    nxt = {1'b0, s[31:1]};
    if (s[0]) begin
      nxt = nxt ^ LfsrTaps;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tcdm_req_gen_lfsr.sv
// 32-bit Galois LFSR used as the random source of the TCDM initiator.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset, loads Seed
//   en_i   - advance the LFSR by one step this cycle
//   lfsr_o - current LFSR state
module tcdm_req_lfsr
  import tcdm_req_gen_pkg::*;
#(
  parameter logic [31:0] Seed = 32'hACE1_0001
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [31:0] lfsr_o
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  // Next-state: hold or advance one Galois step.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = lfsr_step(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/tcdm_req_gen.sv
// TCDM traffic initiator. Writes a known pattern to every bank, then issues a
// pseudo-random read/write mix, tracking in-flight requests in a scoreboard
// indexed by meta_id and checking returned read data against a shadow memory.
// Ports:
//   clk_i / rst_i          - clock, asynchronous active-high reset
//   start_i                - start pulse, honoured only in IDLE or DONE
//   req_valid_o/req_ready_i/req_o    - request channel to the adapter
//   resp_valid_i/resp_ready_o/resp_i - response channel from the adapter
//   busy_o                 - run in progress (INIT/ISSUE/DRAIN)
//   done_o                 - run complete, all responses returned
//   error_o / err_cnt_o    - sticky error flag and saturating error count
module tcdm_req_gen
  import tcdm_req_gen_pkg::*;
#(
  parameter int unsigned NumIterations  = 100,
  parameter int unsigned NumTcdmBanks   = 16,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned CoreId         = 0,
  parameter int unsigned TileId         = 0,
  parameter logic [31:0] Seed           = 32'hACE1_0001
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output tcdm_req_t   req_o,
  input  logic        resp_valid_i,
  output logic        resp_ready_o,
  input  tcdm_resp_t  resp_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] err_cnt_o
);

  localparam int unsigned BankW = (NumTcdmBanks > 1) ? $clog2(NumTcdmBanks) : 1;
  localparam int unsigned SbW   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  tcdm_req_gen_state_e state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;        // INIT bank index / ISSUE request count
  logic [SbW-1:0]      alloc_q, alloc_d;    // next meta_id to hand out
  sb_entry_t           sb_q [MaxOutstanding];
  sb_entry_t           sb_d [MaxOutstanding];
  logic [31:0]         shadow_q [NumTcdmBanks];
  logic [31:0]         shadow_d [NumTcdmBanks];
  logic                error_q, error_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic                resp_ready_q;

  logic [31:0]         lfsr_s;
  logic                lfsr_en_s;
  logic                clear_run_s;
  logic                req_valid_s;
  logic                req_fire_s;
  logic [BankW-1:0]    req_bank_s;
  logic                req_write_s;
  logic [31:0]         req_wdata_s;
  tcdm_req_t           req_s;
  logic                resp_fire_s;
  logic                resp_in_range_s;
  logic [SbW-1:0]      resp_idx_s;
  logic                resp_err_s;
  logic                sb_empty_s;
  logic                unused_resp_s;

  assign unused_resp_s = ^{resp_i.meta.lrwait, resp_i.meta.ini_addr};

  tcdm_req_lfsr #(
    .Seed(Seed)
  ) i_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (lfsr_en_s),
    .lfsr_o(lfsr_s)
  );

  // Request payload: INIT walks the banks in order, ISSUE draws from the LFSR.
  always_comb begin
    req_bank_s  = '0;
    req_write_s = 1'b0;
    req_wdata_s = 32'h0000_0000;
    if (state_q == ST_INIT) begin
      req_bank_s  = BankW'(cnt_q);
      req_write_s = 1'b1;
      req_wdata_s = {16'hB000 | cnt_q, 16'(CoreId)};
    end else begin
      req_bank_s  = BankW'(lfsr_s % 32'(NumTcdmBanks));
      req_write_s = lfsr_s[31];
      req_wdata_s = lfsr_s ^ WdataMask;
    end
  end

  // Valid depends only on registered state, so ready never feeds back into it.
  always_comb begin
    req_valid_s = 1'b0;
    if ((state_q == ST_INIT) || (state_q == ST_ISSUE)) begin
      req_valid_s = !sb_q[alloc_q].busy;
    end else begin
      req_valid_s = 1'b0;
    end
  end

  assign req_fire_s = req_valid_s & req_ready_i;
  assign lfsr_en_s  = req_fire_s && (state_q == ST_ISSUE);

  // Request bus assembly; zero whenever no request is offered.
  always_comb begin
    req_s = '0;
    if (req_valid_s) begin
      req_s.addr          = {{(32-BankW-2){1'b0}}, req_bank_s, 2'b00};
      req_s.write         = req_write_s;
      req_s.amo           = 4'h0;
      req_s.data          = req_wdata_s;
      req_s.be            = 4'hF;
      req_s.meta.ini_addr = IniAddrWidth'(CoreId);
      req_s.meta.meta_id  = MetaIdWidth'(alloc_q);
      req_s.meta.tile_id  = TileIdWidth'(TileId);
      req_s.meta.core_id  = CoreIdWidth'(CoreId);
      req_s.meta.lrwait   = 1'b0;
    end else begin
      req_s = '0;
    end
  end

  // Main FSM next-state, counters and meta_id allocation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alloc_d     = alloc_q;
    clear_run_s = 1'b0;
    if (req_fire_s) begin
      if (alloc_q == SbW'(MaxOutstanding - 1)) begin
        alloc_d = '0;
      end else begin
        alloc_d = alloc_q + 1'b1;
      end
    end else begin
      alloc_d = alloc_q;
    end
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d     = ST_INIT;
          cnt_d       = 16'd0;
          alloc_d     = '0;
          clear_run_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_INIT: begin
        if (req_fire_s) begin
          if (cnt_q == 16'(NumTcdmBanks - 1)) begin
            state_d = ST_ISSUE;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_ISSUE: begin
        if (req_fire_s) begin
          if (cnt_q == 16'(NumIterations - 1)) begin
            state_d = ST_DRAIN;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_DRAIN: begin
        if (sb_empty_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Scoreboard occupancy.
  always_comb begin
    sb_empty_s = 1'b1;
    for (int i = 0; i < int'(MaxOutstanding); i++) begin
      if (sb_q[i].busy) begin
        sb_empty_s = 1'b0;
      end else begin
        sb_empty_s = sb_empty_s;
      end
    end
  end

  assign resp_fire_s     = resp_valid_i & resp_ready_q;
  assign resp_in_range_s = (32'(resp_i.meta.meta_id) < MaxOutstanding);
  assign resp_idx_s      = SbW'(resp_i.meta.meta_id);

  // Response check: unknown/duplicate id, wrong read data or foreign metadata.
  always_comb begin
    resp_err_s = 1'b0;
    if (resp_fire_s) begin
      if (!resp_in_range_s || !sb_q[resp_idx_s].busy) begin
        resp_err_s = 1'b1;
      end else if (!sb_q[resp_idx_s].is_write &&
                   (resp_i.data != sb_q[resp_idx_s].expected)) begin
        resp_err_s = 1'b1;
      end else begin
        resp_err_s = 1'b0;
      end
      if ((resp_i.meta.core_id != CoreIdWidth'(CoreId)) ||
          (resp_i.meta.tile_id != TileIdWidth'(TileId))) begin
        resp_err_s = 1'b1;
      end else begin
        resp_err_s = resp_err_s;
      end
    end else begin
      resp_err_s = 1'b0;
    end
  end

  // Scoreboard and shadow updates. The response clears first, then a new
  // issue claims its slot, so an erroneous response hitting the slot being
  // allocated cannot wipe the fresh entry.
  always_comb begin
    sb_d     = sb_q;
    shadow_d = shadow_q;
    if (resp_fire_s && resp_in_range_s) begin
      sb_d[resp_idx_s] = '0;
    end else begin
      sb_d[resp_idx_s] = sb_d[resp_idx_s];
    end
    if (req_fire_s) begin
      sb_d[alloc_q].busy     = 1'b1;
      sb_d[alloc_q].is_write = req_write_s;
      sb_d[alloc_q].expected = shadow_q[req_bank_s];
      if (req_write_s) begin
        shadow_d[req_bank_s] = req_wdata_s;
      end else begin
        shadow_d[req_bank_s] = shadow_q[req_bank_s];
      end
    end else begin
      sb_d[alloc_q] = sb_d[alloc_q];
    end
  end

  // Sticky error flag and saturating error counter, cleared on each start.
  always_comb begin
    error_d   = error_q;
    err_cnt_d = err_cnt_q;
    if (clear_run_s) begin
      error_d   = 1'b0;
      err_cnt_d = 16'd0;
    end else if (resp_err_s) begin
      error_d = 1'b1;
      if (err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      error_d = error_q;
    end
  end

  // State, scoreboard, shadow and status registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      alloc_q      <= '0;
      error_q      <= 1'b0;
      err_cnt_q    <= 16'd0;
      resp_ready_q <= 1'b0;
      for (int i = 0; i < int'(MaxOutstanding); i++) begin
        sb_q[i] <= '0;
      end
      for (int b = 0; b < int'(NumTcdmBanks); b++) begin
        shadow_q[b] <= 32'h0000_0000;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alloc_q      <= alloc_d;
      error_q      <= error_d;
      err_cnt_q    <= err_cnt_d;
      resp_ready_q <= 1'b1;
      sb_q         <= sb_d;
      shadow_q     <= shadow_d;
    end
  end

  assign req_valid_o  = req_valid_s;
  assign req_o        = req_s;
  assign resp_ready_o = resp_ready_q;
  assign busy_o       = (state_q == ST_INIT) || (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done_o       = (state_q == ST_DONE);
  assign error_o      = error_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_tcdm_req_gen.sv
// Self-checking bench for tcdm_req_gen: table-driven control vectors,
// a bank-memory responder, and a transaction-level reference model.
module tb_tcdm_req_gen;
  import tcdm_req_gen_pkg::*;

  localparam int NB    = 16;
  localparam int NIT   = 100;
  localparam int MAXO  = 8;
  localparam int TOTAL = NB + NIT;
  localparam logic [31:0] SEED = 32'hACE1_0001;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       req_valid_o;
  logic       req_ready_i = 1'b0;
  tcdm_req_t  req_o;
  logic       resp_valid_i = 1'b0;
  logic       resp_ready_o;
  tcdm_resp_t resp_i = '0;
  logic       busy_o, done_o, error_o;
  logic [15:0] err_cnt_o;

  tcdm_req_gen #(
    .NumIterations(NIT), .NumTcdmBanks(NB), .MaxOutstanding(MAXO),
    .CoreId(0), .TileId(0), .Seed(SEED)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_o(req_o),
    .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o), .resp_i(resp_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model + responder ----------------
  typedef enum int {R_IDEAL, R_RANDOM, R_WITHHOLD, R_ONE} rmode_e;
  typedef struct { int id; logic [31:0] data; bit is_write; int due; } rsp_t;

  rsp_t        rq[$];
  bit          inflight [MAXO];
  logic [31:0] mem [NB];
  logic [31:0] lfsr_m = SEED;
  int          acc_cnt = 0;
  int          acc_limit = 1 << 30;
  int          m_errs = 0;
  bit          m_active = 1'b0;
  bit          corrupt_pending = 1'b0;
  bit          ready_force = 1'b1;
  rmode_e      rmode = R_IDEAL;
  int          cyc = 0;

  // Request number k as the initiator must present it.
  function automatic tcdm_req_t exp_req(input int k);
    tcdm_req_t r;
    int bank;
    r = '0;
    if (k < NB) begin
      bank = k;
      r.write = 1'b1;
      r.data = {16'hB000 + 16'(k), 16'h0000};
    end else begin
      bank = int'(lfsr_m % 32'(NB));
      r.write = lfsr_m[31];
      r.data = lfsr_m ^ 32'h5A5A_5A5A;
    end
    r.addr = 32'(bank * 4);
    r.be = 4'hF;
    r.meta.meta_id = 4'(k % MAXO);
    return r;
  endfunction

  task automatic accept();
    tcdm_req_t r;
    rsp_t p;
    int bank;
    r = exp_req(acc_cnt);
    bank = int'(r.addr) / 4;
    p.id = acc_cnt % MAXO;
    p.is_write = r.write;
    p.due = cyc + 1;
    if (r.write) begin
      p.data = $urandom;
      mem[bank] = r.data;
    end else begin
      p.data = mem[bank];
    end
    rq.push_back(p);
    inflight[p.id] = 1'b1;
    if (acc_cnt >= NB) begin
      lfsr_m = lfsr_m[0] ? ((lfsr_m >> 1) ^ 32'h8020_0003) : (lfsr_m >> 1);
    end
    acc_cnt++;
  endtask

  // One clock: check at the falling edge, then set inputs for the next rise.
  task automatic cycle();
    logic exp_valid;
    rsp_t r;
    bit go;
    @(negedge clk);
    cyc++;
    exp_valid = m_active && (acc_cnt < TOTAL) && !inflight[acc_cnt % MAXO];
    chk("req_valid", req_valid_o, exp_valid);
    chk("err_cnt", err_cnt_o, m_errs);
    chk("error", error_o, m_errs != 0);
    if (req_valid_o && exp_valid) chk("req_payload", req_o, exp_req(acc_cnt));
    resp_valid_i = 1'b0;
    resp_i = '0;
    go = 1'b0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      if (rmode == R_IDEAL || rmode == R_ONE) go = 1'b1;
      else if (rmode == R_RANDOM) go = ($urandom_range(0, 2) != 0);
      else go = 1'b0;
    end
    if (go) begin
      r = rq.pop_front();
      resp_valid_i = 1'b1;
      resp_i.data = r.data;
      resp_i.meta.meta_id = 4'(r.id);
      if (!r.is_write && corrupt_pending) begin
        resp_i.data = r.data ^ 32'h1;
        corrupt_pending = 1'b0;
        if (m_errs < 65535) m_errs++;
      end
      inflight[r.id] = 1'b0;
      if (rmode == R_ONE) rmode = R_WITHHOLD;
    end
    if (acc_cnt >= acc_limit) req_ready_i = 1'b0;
    else if (rmode == R_RANDOM) req_ready_i = 1'($urandom_range(0, 1));
    else req_ready_i = ready_force;
    if (req_valid_o && req_ready_i) accept();
  endtask

  task automatic start_run();
    start_i = 1'b1;
    m_active = 1'b1;
    acc_cnt = 0;
    m_errs = 0;
    acc_limit = 1 << 30;
    cycle();
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1'b1);
    chk("done_after_start", done_o, 1'b0);
  endtask

  task automatic run_to_done(input string name, input int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      cycle();
      n++;
    end
    chk(name, done_o, 1'b1);
    chk({name, "_accepted"}, acc_cnt, TOTAL);
    chk({name, "_busy"}, busy_o, 1'b0);
  endtask

  // ---------------- control vector table ----------------
  typedef struct {
    string name;
    logic rst, start, rv;
    logic [3:0] mid;
    logic busy, done, valid, err;
    logic [15:0] cnt;
    logic rdy;
  } vec_t;

  vec_t vec [10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tcdm_req_t held;
    int n;
    foreach (mem[b]) mem[b] = 32'h0;
    foreach (inflight[i]) inflight[i] = 1'b0;

    vec[0] = '{"reset",        1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0};
    vec[1] = '{"idle",         1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1};
    vec[2] = '{"unknown_id3",  1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1};
    vec[3] = '{"unknown_id5",  1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b1};
    vec[4] = '{"sticky",       1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b1};
    vec[5] = '{"unknown_id0",  1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3, 1'b1};
    vec[6] = '{"start_clears", 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1};
    vec[7] = '{"start_ignored",1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1};
    vec[8] = '{"abort_reset",  1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0};
    vec[9] = '{"release",      1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1};

    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rst_i = vec[i].rst;
      start_i = vec[i].start;
      resp_valid_i = vec[i].rv;
      resp_i = '0;
      resp_i.meta.meta_id = vec[i].mid;
      req_ready_i = 1'b0;
      @(negedge clk);
      chk({vec[i].name, "_busy"}, busy_o, vec[i].busy);
      chk({vec[i].name, "_done"}, done_o, vec[i].done);
      chk({vec[i].name, "_valid"}, req_valid_o, vec[i].valid);
      chk({vec[i].name, "_error"}, error_o, vec[i].err);
      chk({vec[i].name, "_errcnt"}, err_cnt_o, vec[i].cnt);
      chk({vec[i].name, "_rdy"}, resp_ready_o, vec[i].rdy);
    end
    start_i = 1'b0;
    resp_valid_i = 1'b0;
    resp_i = '0;

    // Ideal responder: full run with no errors.
    rmode = R_IDEAL;
    ready_force = 1'b1;
    start_run();
    run_to_done("ideal_done", 2000);
    chk("ideal_error", error_o, 1'b0);
    chk("ideal_errcnt", err_cnt_o, 16'd0);

    // Backpressure: payload must hold while ready is low.
    ready_force = 1'b0;
    start_run();
    held = req_o;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("stall_valid", req_valid_o, 1'b1);
      chk("stall_hold", req_o, held);
    end
    ready_force = 1'b1;
    cycle();
    ready_force = 1'b0;
    cycle();
    chk("stall_one_transfer", acc_cnt, 1);
    ready_force = 1'b1;
    run_to_done("stall_done", 2000);

    // Withheld responses: stop at the outstanding cap.
    rmode = R_WITHHOLD;
    start_run();
    for (int i = 0; i < 40; i++) cycle();
    chk("cap_accepted", acc_cnt, MAXO);
    chk("cap_valid_low", req_valid_o, 1'b0);
    rmode = R_ONE;
    cycle();
    cycle();
    chk("cap_release_valid", req_valid_o, 1'b1);
    for (int i = 0; i < 5; i++) cycle();
    chk("cap_release_one", acc_cnt, MAXO + 1);
    rmode = R_IDEAL;
    run_to_done("cap_done", 2000);

    // Random ready and response timing, clean.
    rmode = R_RANDOM;
    start_run();
    run_to_done("rand_done", 6000);
    chk("rand_errcnt", err_cnt_o, 16'd0);

    // Random run with one corrupted read response.
    start_run();
    corrupt_pending = 1'b1;
    run_to_done("corrupt_done", 6000);
    chk("corrupt_error", error_o, 1'b1);
    chk("corrupt_errcnt", err_cnt_o, 16'd1);

    // Idle meta_id injected after the run, then saturation.
    resp_i = '0;
    resp_i.meta.meta_id = 4'd3;
    resp_valid_i = 1'b1;
    @(negedge clk);
    resp_valid_i = 1'b0;
    @(negedge clk);
    chk("inject_id3", err_cnt_o, 16'd2);
    for (int i = 0; i < 65540; i++) begin
      resp_i.meta.meta_id = 4'(i % MAXO);
      resp_valid_i = 1'b1;
      @(negedge clk);
    end
    resp_valid_i = 1'b0;
    resp_i = '0;
    @(negedge clk);
    chk("saturate_cnt", err_cnt_o, 16'hFFFF);
    chk("saturate_error", error_o, 1'b1);

    // Mid-run reset during ISSUE with five requests in flight.
    rmode = R_IDEAL;
    start_run();
    acc_limit = NB;
    n = 0;
    while (!(acc_cnt == NB && rq.size() == 0) && n < 300) begin cycle(); n++; end
    rmode = R_WITHHOLD;
    acc_limit = NB + 5;
    n = 0;
    while (acc_cnt < NB + 5 && n < 300) begin cycle(); n++; end
    cycle();
    chk("pre_reset_busy", busy_o, 1'b1);
    rst_i = 1'b1;
    #1;
    chk("rst_valid", req_valid_o, 1'b0);
    chk("rst_req", req_o, '0);
    chk("rst_resp_ready", resp_ready_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    @(negedge clk);
    rst_i = 1'b0;
    acc_cnt = 0;
    rq.delete();
    foreach (inflight[i]) inflight[i] = 1'b0;
    lfsr_m = SEED;
    m_active = 1'b0;
    m_errs = 0;
    acc_limit = 1 << 30;
    rmode = R_IDEAL;
    cycle();
    cycle();
    start_run();
    chk("restart_addr", req_o.addr, 32'h0);
    chk("restart_meta_id", req_o.meta.meta_id, 4'd0);
    run_to_done("restart_done", 2000);
    chk("restart_error", error_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
